// File: rtl/fg_burst_waveform_gen.sv
// Trapezoid burst waveform generator: internal period counter, shadowed config,
// one-shot/burst/continuous sequencing and offset/invert output mapping.
module fg_burst_waveform_gen #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16,
  parameter int unsigned BURST_BITWIDTH    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         strb_data_valid_i,
  input  logic                         trigger_i,
  input  logic                         cfg_load_i,
  input  logic [COUNTER_BITWIDTH-1:0]  period_i,
  input  logic [COUNTER_BITWIDTH-1:0]  delay_i,
  input  logic [COUNTER_BITWIDTH-1:0]  on_count_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] amplitude_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] offset_i,
  input  logic                         invert_i,
  input  logic [BURST_BITWIDTH-1:0]    burst_count_i,
  output logic [WAVEFORM_BITWIDTH-1:0] out_o,
  output logic                         strb_data_valid_o,
  output logic                         busy_o,
  output logic                         burst_done_o
);

  localparam int unsigned CW = COUNTER_BITWIDTH;
  localparam int unsigned WW = WAVEFORM_BITWIDTH;
  localparam int unsigned BW = BURST_BITWIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_RISE  = 3'd2,
    S_ON    = 3'd3,
    S_FALL  = 3'd4,
    S_LOW   = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] val;
  logic [BW-1:0] burst_rem;
  logic          pending;
  logic          strb_d;

  logic [CW-1:0] sh_period;
  logic [CW-1:0] sh_delay;
  logic [CW-1:0] sh_on;
  logic [WW-1:0] sh_k_rise;
  logic [WW-1:0] sh_k_fall;
  logic [WW-1:0] sh_amp;
  logic [WW-1:0] sh_offset;
  logic          sh_invert;
  logic [BW-1:0] sh_burst;

  logic          tick;
  logic          wrap;
  logic          load_shadow;
  logic [WW:0]   rise_sum;
  logic [WW:0]   fall_diff;
  logic [WW:0]   out_sum;
  logic [WW-1:0] rise_val;
  logic [WW-1:0] fall_val;
  logic [WW-1:0] mapped;
  logic [WW-1:0] out_next;

  assign tick        = strb_data_valid_i;
  assign wrap        = (cnt == sh_period);
  assign load_shadow = (state == S_IDLE) || (enable_i && tick && wrap && pending);

  // Step arithmetic one bit wider so carry/borrow drive the clamps.
  always_comb begin
    rise_sum  = {1'b0, val} + {1'b0, sh_k_rise};
    fall_diff = {1'b0, val} - {1'b0, sh_k_fall};
    rise_val  = (rise_sum > {1'b0, sh_amp}) ? sh_amp : rise_sum[WW-1:0];
    fall_val  = fall_diff[WW] ? '0 : fall_diff[WW-1:0];
    mapped    = sh_invert ? (sh_amp - val) : val;
    out_sum   = {1'b0, sh_offset} + {1'b0, mapped};
    out_next  = out_sum[WW] ? '1 : out_sum[WW-1:0];
  end

  // Shadow config: tracks inputs while idle, otherwise only at a pending wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_period <= '0;
      sh_delay  <= '0;
      sh_on     <= '0;
      sh_k_rise <= '0;
      sh_k_fall <= '0;
      sh_amp    <= '0;
      sh_offset <= '0;
      sh_invert <= 1'b0;
      sh_burst  <= '0;
    end else if (load_shadow) begin
      sh_period <= period_i;
      sh_delay  <= delay_i;
      sh_on     <= on_count_i;
      sh_k_rise <= k_rise_i;
      sh_k_fall <= k_fall_i;
      sh_amp    <= amplitude_i;
      sh_offset <= offset_i;
      sh_invert <= invert_i;
      sh_burst  <= burst_count_i;
    end
  end

  // Sequencer: state, counter, level and burst bookkeeping advance on ticks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      val          <= '0;
      burst_rem    <= '0;
      pending      <= 1'b0;
      busy_o       <= 1'b0;
      burst_done_o <= 1'b0;
    end else begin
      burst_done_o <= 1'b0;
      if (!enable_i) begin
        state   <= S_IDLE;
        cnt     <= '0;
        val     <= '0;
        pending <= 1'b0;
        busy_o  <= 1'b0;
      end else if (state == S_IDLE) begin
        cnt     <= '0;
        val     <= '0;
        pending <= 1'b0;
        if (tick && ((sh_burst == '0) || trigger_i)) begin
          state     <= S_DELAY;
          burst_rem <= sh_burst;
          busy_o    <= 1'b1;
        end
      end else begin
        if (tick && wrap) pending <= cfg_load_i;
        else if (cfg_load_i) pending <= 1'b1;

        if (tick) begin
          cnt <= wrap ? '0 : cnt + CW'(1);
          if (wrap) begin
            val   <= '0;
            state <= S_DELAY;
            if (sh_burst != '0) begin
              if (burst_rem <= BW'(1)) begin
                state        <= S_IDLE;
                burst_rem    <= '0;
                busy_o       <= 1'b0;
                burst_done_o <= 1'b1;
              end else begin
                burst_rem <= burst_rem - BW'(1);
              end
            end
          end else begin
            case (state)
              S_DELAY: if (cnt == sh_delay) state <= S_RISE;
              S_RISE: begin
                if (cnt == sh_on) begin
                  state <= S_FALL;
                end else begin
                  val <= rise_val;
                  if (rise_val == sh_amp) state <= S_ON;
                end
              end
              S_ON:    if (cnt == sh_on) state <= S_FALL;
              S_FALL: begin
                val <= fall_val;
                if (fall_val == '0) state <= S_LOW;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Output mapping and strobe alignment run every clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_o             <= '0;
      strb_d            <= 1'b0;
      strb_data_valid_o <= 1'b0;
    end else begin
      out_o             <= out_next;
      strb_d            <= strb_data_valid_i;
      strb_data_valid_o <= strb_d;
    end
  end

endmodule

// File: tb/tb_fg_burst_waveform_gen.sv
// Scoreboard bench for fg_burst_waveform_gen: expected samples are queued per
// driven tick and compared when the output strobe qualifies out_o.
module tb_fg_burst_waveform_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        strb = 1'b0;
  logic        trigger = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] period = '0;
  logic [31:0] delay = '0;
  logic [31:0] on_count = '0;
  logic [15:0] k_rise = '0;
  logic [15:0] k_fall = '0;
  logic [15:0] amplitude = '0;
  logic [15:0] offset = '0;
  logic        invert = 1'b0;
  logic [7:0]  burst_count = 8'd1;
  logic [15:0] out;
  logic        valid;
  logic        busy;
  logic        burst_done;

  int          n_checks = 0;
  int          n_errors = 0;
  int          bd_cnt = 0;
  logic        stable_en = 1'b0;
  logic [15:0] last_out = '0;
  logic [15:0] exp_q[$];
  int          pat[2][10] = '{'{0, 0, 4, 8, 10, 10, 10, 7, 4, 0},
                              '{0, 0, 4, 5, 5, 5, 5, 2, 0, 0}};

  fg_burst_waveform_gen dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .strb_data_valid_i (strb),
    .trigger_i         (trigger),
    .cfg_load_i        (cfg_load),
    .period_i          (period),
    .delay_i           (delay),
    .on_count_i        (on_count),
    .k_rise_i          (k_rise),
    .k_fall_i          (k_fall),
    .amplitude_i       (amplitude),
    .offset_i          (offset),
    .invert_i          (invert),
    .burst_count_i     (burst_count),
    .out_o             (out),
    .strb_data_valid_o (valid),
    .busy_o            (busy),
    .burst_done_o      (burst_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops one expectation per qualified sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("out", 32'(out), 32'(exp_q.pop_front()));
      end else if (stable_en) begin
        check("stable", 32'(out), 32'(last_out));
      end
      if (burst_done) bd_cnt++;
      last_out = out;
    end
  end

  task automatic set_cfg(input int per, input int dly, input int on, input int kr, input int kf,
                         input int amp, input int ofs, input int inv, input int bst);
    period      = 32'(per);
    delay       = 32'(dly);
    on_count    = 32'(on);
    k_rise      = 16'(kr);
    k_fall      = 16'(kf);
    amplitude   = 16'(amp);
    offset      = 16'(ofs);
    invert      = 1'(inv);
    burst_count = 8'(bst);
    repeat (2) @(negedge clk);
  endtask

  task automatic tick(input logic trig, input logic [15:0] exp, input int gap);
    strb    = 1'b1;
    trigger = trig;
    exp_q.push_back(exp);
    @(negedge clk);
    strb    = 1'b0;
    trigger = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic play(input int p, input int ofs, input int gap, input logic trig);
    for (int i = 0; i < 10; i++) tick(trig, 16'(pat[p][i] + ofs), gap);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_done(input string tag, input int exp);
    check(tag, 32'(bd_cnt), 32'(exp));
    bd_cnt = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    rst = 1'b0;

    // Single-period burst shape.
    set_cfg(9, 1, 6, 4, 3, 10, 0, 0, 1);
    tick(1'b1, 16'd0, 0);
    check("s1_busy_run", 32'(busy), 32'd1);
    play(0, 0, 0, 1'b0);
    check("s1_busy_end", 32'(busy), 32'd0);
    tick(1'b0, 16'd0, 0);
    drain("s1_drain");
    check_done("s1_done_cnt", 1);

    // Rise clamp, output saturation, inverted idle mapping.
    set_cfg(5, 0, 4, 'h8000, 'h8000, 'hFFF0, 'h20, 0, 1);
    tick(1'b1, 16'h0020, 0);
    tick(1'b0, 16'h0020, 0);
    tick(1'b0, 16'h8020, 0);
    tick(1'b0, 16'hFFFF, 0);
    tick(1'b0, 16'hFFFF, 0);
    tick(1'b0, 16'hFFFF, 0);
    tick(1'b0, 16'h0020, 0);
    invert = 1'b1;
    tick(1'b0, 16'hFFFF, 0);
    offset = 16'h0000;
    tick(1'b0, 16'hFFF0, 0);
    drain("s2_drain");
    check_done("s2_done_cnt", 1);

    // Three-period burst, triggers while busy ignored.
    set_cfg(9, 1, 6, 4, 3, 10, 0, 0, 3);
    tick(1'b1, 16'd0, 0);
    for (int r = 0; r < 3; r++) play(0, 0, 0, 1'b1);
    check("s3_busy_end", 32'(busy), 32'd0);
    tick(1'b0, 16'd0, 0);
    tick(1'b0, 16'd0, 0);
    check("s3_idle", 32'(busy), 32'd0);
    drain("s3_drain");
    check_done("s3_done_cnt", 1);

    // Continuous mode with a shadowed amplitude change mid-period.
    set_cfg(9, 1, 6, 4, 3, 10, 0, 0, 0);
    tick(1'b0, 16'd0, 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 16'(pat[0][i]), 0);
    amplitude = 16'd5;
    cfg_load  = 1'b1;
    @(negedge clk);
    cfg_load  = 1'b0;
    for (int i = 4; i < 10; i++) tick(1'b0, 16'(pat[0][i]), 0);
    play(1, 0, 0, 1'b0);
    check("s4_busy_cont", 32'(busy), 32'd1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("s4_busy_off", 32'(busy), 32'd0);
    burst_count = 8'd1;
    enable = 1'b1;
    drain("s4_drain");
    check_done("s4_done_cnt", 0);

    // Strobe every third clock; output must hold between ticks.
    set_cfg(9, 1, 6, 4, 3, 10, 0, 0, 1);
    stable_en = 1'b1;
    tick(1'b1, 16'd0, 2);
    play(0, 0, 2, 1'b0);
    tick(1'b0, 16'd0, 2);
    drain("s5_drain");
    stable_en = 1'b0;
    check_done("s5_done_cnt", 1);

    // Delay beyond period: flat output, single period then idle.
    set_cfg(3, 5, 2, 4, 3, 10, 0, 0, 1);
    tick(1'b1, 16'd0, 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 16'd0, 0);
    check("s7_busy_end", 32'(busy), 32'd0);
    drain("s7_drain");
    check_done("s7_done_cnt", 1);

    // Disable during ON, then asynchronous reset during RISE.
    set_cfg(9, 1, 6, 4, 3, 10, 3, 0, 1);
    tick(1'b1, 16'd3, 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'(pat[0][i] + 3), 0);
    repeat (2) @(negedge clk);
    check("s6_on_out", 32'(out), 32'd13);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("s6_dis_busy", 32'(busy), 32'd0);
    check("s6_dis_out", 32'(out), 32'd3);
    enable = 1'b1;
    tick(1'b0, 16'd3, 0);
    drain("s6_drain");
    check_done("s6_done_cnt", 0);
    tick(1'b1, 16'd3, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 16'(pat[0][i] + 3), 0);
    repeat (2) @(negedge clk);
    check("s6_pre_rst", 32'(out), 32'd7);
    rst = 1'b1;
    #1;
    check("s6_rst_out", 32'(out), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
